wb_xbar_arb: RTL and testbench
==============================

# wb_xbar_arb

Parametrised Wishbone interconnect for FazyRV SoCs: arbitrates NMST Wishbone-classic masters (CPU imem/dmem, future DMA or debug) onto NSLV address-decoded slaves (QSPI memory, GPIO, further peripherals). Arbitration and decode are registered, selectable as round-robin or fixed priority. A bus-error path answers unmapped addresses. A watchdog terminates hung slave cycles with an error. It replaces hand-wired imem/dmem muxing and single-bit address selects in SoC tops.

## Interface
- NMST, 2: number of masters (1..8).
- NSLV, 2: number of slaves (1..8).
- SLV_BASE, {32'h1000_0000, 32'h0000_0000}: NSLV×32 concatenated base addresses; slave i uses bits [32*i+:32].
- SLV_MASK, {32'hF000_0000, 32'hF000_0000}: NSLV×32 concatenated decode masks, same packing.
- ARB_MODE, "RR": "RR" selects round-robin; "FIXED" gives the lowest index highest priority.
- TIMEOUT, 255: BUSY cycles without ack before an error is returned; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_in  in  1  reset; asynchronous and active-low.
- m_stb_i  in  NMST  per-master request (stb = cyc).
- m_we_i  in  NMST  per-master write enable.
- m_be_i  in  4*NMST  byte enables, master j at [4*j+:4].
- m_adr_i  in  32*NMST  addresses.
- m_dat_i  in  32*NMST  write data.
- m_dat_o  out  32  read data, shared by all masters.
- m_ack_o  out  NMST  per-master ack.
- m_err_o  out  NMST  per-master bus error.
- s_stb_o  out  NSLV  per-slave strobe.
- s_we_o  out  1  write enable.
- s_be_o  out  4  byte enables.
- s_adr_o  out  32  address.
- s_dat_o  out  32  write data.
- s_dat_i  in  32*NSLV  slave read data.
- s_ack_i  in  NSLV  slave acks.

## Operation
- The FSM has three states: IDLE, BUSY and ERR. Registered state: gnt (master index), sel (slave index), rr_ptr (last granted master) and wdg counter (width $clog2(TIMEOUT+1)).
- IDLE:
  - If any m_stb_i is set, pick a winner.
    - RR: the first requester scanning upward from rr_ptr+1, modulo NMST.
    - FIXED: the lowest index.
  - Latch gnt and, in RR mode, set rr_ptr to the winner.
  - Decode the winner's address: sel is the lowest i with (adr & MASK_i) == BASE_i.
  - On a match, go to BUSY with wdg cleared. With no match, go to ERR.
- BUSY:
  - s_stb_o[sel] = m_stb_i[gnt]. s_we_o, s_be_o, s_adr_o and s_dat_o come from master gnt.
  - m_dat_o = s_dat_i[sel].
  - If s_ack_i[sel] and m_stb_i[gnt] are both high: m_ack_o[gnt] = 1 in the same cycle, then go to IDLE.
  - If m_stb_i[gnt] drops before ack, the transaction is abandoned: s_stb_o is low in that cycle, any ack is discarded, then go to IDLE.
  - If TIMEOUT ≠ 0, wdg increments each BUSY cycle without ack. When wdg == TIMEOUT-1 with no ack, go to ERR.
- ERR: m_err_o[gnt] = 1 for exactly one cycle, all s_stb_o are low, then go to IDLE.
- Outputs when no grant is active (IDLE/ERR):
  - All s_stb_o are 0.
  - s_we_o, s_be_o, s_adr_o, s_dat_o and m_dat_o are 0.
  - m_ack_o is 0.
- Never more than one bit of s_stb_o, m_ack_o or m_err_o is set.
- A slave ack in IDLE, ERR, or from a non-selected slave is ignored.
- Reset, asynchronous, any state:
  - State goes to IDLE and wdg to 0.
  - gnt and sel go to 0.
  - rr_ptr goes to NMST-1, so master 0 has first priority.
  - All outputs are 0 immediately.

## Timing
- Request in cycle 0 leads to s_stb_o in cycle 1 (one registered arbitration cycle).
- A zero-wait slave acks in cycle 1, giving m_ack_o in cycle 1.
- After every ack or error the bus passes through one IDLE cycle. Sustained throughput is 2 cycles per transfer for zero-wait slaves.
- Unmapped address: m_err_o in cycle 1.
- Hung slave: s_stb_o is high in cycles 1..TIMEOUT, and m_err_o follows in cycle TIMEOUT+1.
- Requests arriving during BUSY or ERR wait; they are evaluated in the next IDLE cycle.
- A master must hold its address, data, we and be stable while stb is high.

## Test plan
- **Single read:** defaults. m0 reads 0x1000_0004 at cycle 0, and slave 1 acks in cycle 3 with 0xDEAD_BEEF.
  - s_stb_o = 2'b10 in cycles 1..3.
  - m_ack_o[0] and m_dat_o = 0xDEAD_BEEF in cycle 3.
  - No s_stb_o in cycle 4.
- **Round-robin contention:** RR mode, m0 and m1 request continuously, zero-wait slaves.
  - Grants run 0,1,0,1.
  - m_ack_o alternates in cycles 1,3,5,7.
- **Fixed priority:** FIXED mode, same stimulus as the round-robin case. Only m0 is acked until it drops stb; then m1 is acked 2 cycles later.
- **Unmapped address:** write to 0x2000_0000.
  - m_err_o[0] is high in cycle 1 only.
  - s_stb_o stays 0 throughout.
  - A late s_ack_i is ignored.
- **Watchdog:** TIMEOUT = 4, slave never acks.
  - s_stb_o is high in cycles 1..4.
  - m_err_o in cycle 5.
  - A following request is granted normally.
- **Reset mid-transaction:** rst_in asserted in the BUSY cycle that precedes the ack.
  - s_stb_o and m_ack_o drop asynchronously.
  - After release, m0 and m1 request together and m0 is granted first.

Source files
------------

// File: rtl/wb_xbar_arb.sv
// Wishbone-classic crossbar arbiter: NMST masters share one registered grant onto
// NSLV address-decoded slaves, with a bus-error path and a hung-slave watchdog.
module wb_xbar_arb #(
    parameter int unsigned        NMST     = 2,
    parameter int unsigned        NSLV     = 2,
    parameter logic [32*NSLV-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [32*NSLV-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter string              ARB_MODE = "RR",
    parameter int unsigned        TIMEOUT  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic [NMST-1:0]      m_stb_i,
    input  logic [NMST-1:0]      m_we_i,
    input  logic [4*NMST-1:0]    m_be_i,
    input  logic [32*NMST-1:0]   m_adr_i,
    input  logic [32*NMST-1:0]   m_dat_i,
    output logic [31:0]          m_dat_o,
    output logic [NMST-1:0]      m_ack_o,
    output logic [NMST-1:0]      m_err_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [32*NSLV-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i
);

    localparam int unsigned GW = (NMST > 1) ? $clog2(NMST) : 1;
    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WDG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit RR_MODE = (ARB_MODE == "RR");

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [WW-1:0]   wdg_q, wdg_d;

    logic [31:0]     adr_a  [NMST];
    logic [31:0]     dat_a  [NMST];
    logic [3:0]      be_a   [NMST];
    logic [31:0]     sdat_a [NSLV];
    logic [NSLV-1:0] hit_v;

    logic [GW-1:0]   cand;
    logic [GW-1:0]   win;
    logic            win_vld;
    logic [31:0]     win_adr;
    logic [SW-1:0]   hit_idx;
    logic            hit;

    for (genvar j = 0; j < NMST; j++) begin : g_mst
        assign adr_a[j] = m_adr_i[32*j +: 32];
        assign dat_a[j] = m_dat_i[32*j +: 32];
        assign be_a[j]  = m_be_i[4*j +: 4];
    end

    assign win_adr = adr_a[win];

    for (genvar j = 0; j < NSLV; j++) begin : g_slv
        assign sdat_a[j] = s_dat_i[32*j +: 32];
        assign hit_v[j]  = (win_adr & SLV_MASK[32*j +: 32]) == SLV_BASE[32*j +: 32];
    end

    // Round-robin scans upward starting just after the last winner.
    always_comb begin
        cand    = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned i = 0; i < NMST; i++) begin
            cand = GW'(RR_MODE ? (32'(rr_q) + 1 + i) % NMST : i);
            if (!win_vld && m_stb_i[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!hit && hit_v[SW'(i)]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            rr_q    <= GW'(NMST - 1);
            wdg_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            wdg_q   <= wdg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        wdg_d   = wdg_q;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        s_stb_o = '0;
        s_we_o  = 1'b0;
        s_be_o  = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d = win;
                    if (RR_MODE) rr_d = win;
                    sel_d   = hit_idx;
                    wdg_d   = '0;
                    state_d = hit ? BUSY : ERR;
                end
            end
            BUSY: begin
                s_stb_o[sel_q] = m_stb_i[gnt_q];
                s_we_o         = m_we_i[gnt_q];
                s_be_o         = be_a[gnt_q];
                s_adr_o        = adr_a[gnt_q];
                s_dat_o        = dat_a[gnt_q];
                m_dat_o        = sdat_a[sel_q];
                m_ack_o[gnt_q] = s_ack_i[sel_q] & m_stb_i[gnt_q];
                // A dropped strobe abandons the cycle; any ack in it is discarded.
                if (!m_stb_i[gnt_q] || s_ack_i[sel_q]) begin
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    if (wdg_q == WDG_LAST) state_d = ERR;
                    else                   wdg_d   = wdg_q + 1'b1;
                end
            end
            ERR: begin
                m_err_o[gnt_q] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_xbar_arb.sv
// Cycle-stepped bench for wb_xbar_arb: one round-robin and one fixed-priority
// instance (both TIMEOUT=4) share stimulus; a negedge monitor scores each cycle.
module tb_wb_xbar_arb;

    localparam logic [31:0] A1  = 32'h1000_0004;
    localparam logic [31:0] A0  = 32'h0000_0010;
    localparam logic [31:0] A18 = 32'h1000_0008;
    localparam logic [31:0] AU  = 32'h2000_0000;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;
    localparam logic [31:0] FD  = 32'h0BAD_F00D;
    localparam logic [1:0]  GN  = 2'd3;

    typedef struct packed {
        logic [1:0]  md;    // 0: check both, 1: rr only, 2: fixed only
        logic [1:0]  stb;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  ack;
        logic [1:0]  es;
        logic [1:0]  ea;
        logic [1:0]  ee;
        logic [31:0] em;
        logic [1:0]  eg;    // granted master on the slave side, GN when none
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_stb, m_we, s_ack;
    logic [7:0]  m_be;
    logic [63:0] m_adr, m_dat, s_dat;

    logic [31:0] rr_mdat, fx_mdat, rr_sadr, fx_sadr, rr_sdat, fx_sdat;
    logic [1:0]  rr_mack, fx_mack, rr_merr, fx_merr, rr_sstb, fx_sstb;
    logic        rr_swe, fx_swe;
    logic [3:0]  rr_sbe, fx_sbe;

    int unsigned checks = 0;
    int unsigned errors = 0;
    vec_t        exp_q[$];
    vec_t        tv[$];
    vec_t        mon_v;

    wb_xbar_arb #(.ARB_MODE("RR"), .TIMEOUT(4)) u_rr (
        .clk_i(clk), .rst_in(rst_n),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_be_i(m_be), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_dat_o(rr_mdat), .m_ack_o(rr_mack), .m_err_o(rr_merr),
        .s_stb_o(rr_sstb), .s_we_o(rr_swe), .s_be_o(rr_sbe), .s_adr_o(rr_sadr),
        .s_dat_o(rr_sdat), .s_dat_i(s_dat), .s_ack_i(s_ack)
    );

    wb_xbar_arb #(.ARB_MODE("FIXED"), .TIMEOUT(4)) u_fx (
        .clk_i(clk), .rst_in(rst_n),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_be_i(m_be), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_dat_o(fx_mdat), .m_ack_o(fx_mack), .m_err_o(fx_merr),
        .s_stb_o(fx_sstb), .s_we_o(fx_swe), .s_be_o(fx_sbe), .s_adr_o(fx_sadr),
        .s_dat_o(fx_sdat), .s_dat_i(s_dat), .s_ack_i(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] md, stb, we, input logic [31:0] a0, a1,
                                input logic [1:0] ack, es, ea, ee,
                                input logic [31:0] em, input logic [1:0] eg);
        vec_t v;
        v.md = md; v.stb = stb; v.we = we; v.a0 = a0; v.a1 = a1; v.ack = ack;
        v.es = es; v.ea = ea; v.ee = ee; v.em = em; v.eg = eg;
        return v;
    endfunction

    task automatic check_dut(input string p, input vec_t v,
                             input logic [1:0] sstb, mack, merr, input logic [31:0] mdat,
                             input logic swe, input logic [3:0] sbe,
                             input logic [31:0] sadr, sdat);
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_be;
        logic        e_we;
        if (v.eg == GN) begin
            e_adr = '0; e_dat = '0; e_be = '0; e_we = 1'b0;
        end else begin
            e_adr = v.eg[0] ? v.a1 : v.a0;
            e_dat = v.eg[0] ? 32'h2222_0000 : 32'h1111_0000;
            e_be  = v.eg[0] ? 4'h3 : 4'hF;
            e_we  = v.we[v.eg[0]];
        end
        chk({p, ".s_stb"}, 32'(sstb), 32'(v.es));
        chk({p, ".m_ack"}, 32'(mack), 32'(v.ea));
        chk({p, ".m_err"}, 32'(merr), 32'(v.ee));
        chk({p, ".m_dat"}, mdat, v.em);
        chk({p, ".s_adr"}, sadr, e_adr);
        chk({p, ".s_dat"}, sdat, e_dat);
        chk({p, ".s_be"},  32'(sbe), 32'(e_be));
        chk({p, ".s_we"},  32'(swe), 32'(e_we));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_v = exp_q.pop_front();
            if (mon_v.md != 2'd2)
                check_dut("rr", mon_v, rr_sstb, rr_mack, rr_merr, rr_mdat, rr_swe, rr_sbe, rr_sadr, rr_sdat);
            if (mon_v.md != 2'd1)
                check_dut("fx", mon_v, fx_sstb, fx_mack, fx_merr, fx_mdat, fx_swe, fx_sbe, fx_sadr, fx_sdat);
        end
    end

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        m_stb = v.stb;
        m_we  = v.we;
        m_adr = {v.a1, v.a0};
        s_ack = v.ack;
        exp_q.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        m_stb = 2'b01;
        m_we  = 2'b00;
        m_be  = {4'h3, 4'hF};
        m_adr = {A18, A1};
        m_dat = {32'h2222_0000, 32'h1111_0000};
        s_dat = {DB, FD};
        s_ack = 2'b11;

        // Round-robin contention: rr grants 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            tv.push_back(mk(2'd1, 2'b11, 2'b10, A0, A18, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, GN));
            if (k % 2 == 0)
                tv.push_back(mk(2'd1, 2'b11, 2'b10, A0, A18, 2'b11, 2'b01, 2'b01, 2'b00, FD, 2'd0));
            else
                tv.push_back(mk(2'd1, 2'b11, 2'b10, A0, A18, 2'b11, 2'b10, 2'b10, 2'b00, DB, 2'd1));
        end
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A0, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        // Single read with a wait-stated slave 1 acking in cycle 3
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b10, 2'b00, 2'b00, DB, 2'd0));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b01, 2'b10, 2'b00, 2'b00, DB, 2'd0));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b10, 2'b10, 2'b01, 2'b00, DB, 2'd0));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        // Fixed priority: m0 wins until it drops, m1 acked two cycles later
        tv.push_back(mk(2'd2, 2'b11, 2'b00, A0, A18, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd2, 2'b11, 2'b00, A0, A18, 2'b11, 2'b01, 2'b01, 2'b00, FD, 2'd0));
        tv.push_back(mk(2'd2, 2'b11, 2'b00, A0, A18, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd2, 2'b11, 2'b00, A0, A18, 2'b11, 2'b01, 2'b01, 2'b00, FD, 2'd0));
        tv.push_back(mk(2'd2, 2'b10, 2'b00, A0, A18, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd2, 2'b10, 2'b00, A0, A18, 2'b11, 2'b10, 2'b10, 2'b00, DB, 2'd1));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A0, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        // Unmapped write: one-cycle error, late acks ignored
        tv.push_back(mk(2'd0, 2'b01, 2'b01, AU, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b01, 2'b01, AU, A18, 2'b11, 2'b00, 2'b00, 2'b01, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b00, 2'b01, AU, A18, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, AU, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        // Watchdog: strobe in cycles 1..4, error in cycle 5, then a normal grant
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, (k == 1) ? 2'b01 : 2'b00,
                            2'b10, 2'b00, 2'b00, DB, 2'd0));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b01, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A0, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A0, A18, 2'b01, 2'b01, 2'b01, 2'b00, FD, 2'd0));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A0, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        // Abandoned cycle: strobe drops, the coincident ack is discarded
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        tv.push_back(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b10, 2'b00, 2'b00, DB, 2'd0));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A1, A18, 2'b10, 2'b00, 2'b00, 2'b00, DB, 2'd0));
        tv.push_back(mk(2'd0, 2'b00, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));

        // Reset holds everything quiet even with a request and acks present
        @(posedge clk);
        #2;
        chk("rst.rr.s_stb", 32'(rr_sstb), 32'h0);
        chk("rst.rr.m_ack", 32'(rr_mack), 32'h0);
        chk("rst.fx.s_stb", 32'(fx_sstb), 32'h0);
        chk("rst.fx.m_err", 32'(fx_merr), 32'h0);
        m_stb = 2'b00;
        s_ack = 2'b00;
        #1 rst_n = 1'b1;

        foreach (tv[i]) apply(tv[i]);

        // Reset asserted mid-cycle in the BUSY cycle before the ack
        apply(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        apply(mk(2'd0, 2'b01, 2'b00, A1, A18, 2'b00, 2'b10, 2'b00, 2'b00, DB, 2'd0));
        @(posedge clk);
        #1;
        chk("pre.rr.s_stb", 32'(rr_sstb), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.rr.s_stb", 32'(rr_sstb), 32'h0);
        chk("arst.fx.s_stb", 32'(fx_sstb), 32'h0);
        s_ack = 2'b10;
        #1;
        chk("arst.rr.m_ack", 32'(rr_mack), 32'h0);
        chk("arst.fx.m_ack", 32'(fx_mack), 32'h0);
        @(posedge clk);
        #3;
        m_stb = 2'b00;
        s_ack = 2'b00;
        rst_n = 1'b1;
        apply(mk(2'd0, 2'b11, 2'b00, A0, A18, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, GN));
        apply(mk(2'd0, 2'b11, 2'b00, A0, A18, 2'b11, 2'b01, 2'b01, 2'b00, FD, 2'd0));
        apply(mk(2'd0, 2'b00, 2'b00, A0, A18, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, GN));

        @(negedge clk);
        #1;
        chk("scoreboard.drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
